gauss_rr_scheduler: RTL

- Sequences the free-running Gaussian sample generator (LFSR → sqrt/log and cos tables → pipelined 17x17 multiplier) and shares its 32-bit sample stream among N_REQ consumer lanes of the Black-Scholes processor.
- Discards warm-up samples after reset and tracks in-flight samples through the multiplier pipeline.
- Buffers samples in a small FIFO and grants them round-robin to requesting lanes.

---
 rtl/gauss_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/gauss_rr_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/gauss_pkg.sv
// Shared definitions for the Gaussian sample scheduler and its arbiter.
package gauss_pkg;

    localparam int GAUSS_W = 32;

    // Ceiling log2, usable in constant expressions for widths.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef enum logic {WARMUP, RUN} sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after the pointer,
// wrapping modulo N_REQ, and reports the pointer value that follows the winner.
module rr_arbiter
    import gauss_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] sel_o,
    output logic             found_o,
    output logic [PW-1:0]    next_ptr_o
);

    // Scan lanes in priority order starting from the pointer; first hit wins.
    always_comb begin
        sel_o      = '0;
        found_o    = 1'b0;
        next_ptr_o = ptr_i;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found_o && (j == (int'(ptr_i) + i) % N_REQ) && req_i[j]) begin
                    found_o    = 1'b1;
                    sel_o[j]   = 1'b1;
                    next_ptr_o = PW'((j + 1) % N_REQ);
                end
            end
        end
    end

endmodule

// File: rtl/gauss_rr_scheduler.sv
// Gaussian sample scheduler: warms up the generator, tracks samples through
// the multiplier pipeline, buffers them and grants them round-robin.
// Optional statistics outputs (grant_count, starve) under GAUSS_STATS_EN.
module gauss_rr_scheduler
    import gauss_pkg::GAUSS_W, gauss_pkg::clog2, gauss_pkg::sched_state_t, gauss_pkg::RUN;
#(
    parameter int N_REQ   = 4,
    parameter int GEN_LAT = 2,
    parameter int WARMUP  = 64,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               gen_en,
    input  logic [GAUSS_W-1:0] gen_data,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    output logic [GAUSS_W-1:0] out_data,
    output logic               out_valid,
    output logic               ready
`ifdef GAUSS_STATS_EN
    ,
    output logic [31:0]        grant_count,
    output logic [N_REQ-1:0]   starve
`endif
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = (N_REQ > 1) ? clog2(N_REQ) : 1;
    localparam int WW = clog2(WARMUP + 1);

    sched_state_t       state_q, state_d;
    logic [WW-1:0]      warm_q, warm_d;
    logic [GEN_LAT-1:0] disc_q, disc_d;
    logic [GEN_LAT-1:0] keep_q, keep_d;
    logic               ready_q, ready_d;

    logic [GAUSS_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      count_q;

    logic [PW-1:0]      ptr_q;
    logic [N_REQ-1:0]   gnt_q;
    logic               out_valid_q;
    logic [GAUSS_W-1:0] out_data_q;

    logic [N_REQ-1:0]   sel;
    logic               found;
    logic [PW-1:0]      next_ptr;
    logic               push, pop, credit_ok;
    int                 inflight;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .sel_o      (sel),
        .found_o    (found),
        .next_ptr_o (next_ptr)
    );

    assign push = keep_q[GEN_LAT-1];
    assign pop  = ready_q && (count_q != '0) && found;

    // Credits: buffered plus in-flight samples, less this cycle's pop, must leave room for one more.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < GEN_LAT; i++) begin
            inflight = inflight + int'(keep_q[i]);
        end
        credit_ok = (int'(count_q) + inflight - int'(pop) + 1) <= DEPTH;
    end

    // Warm-up/run sequencing, generator enable and discard/keep tagging of launches.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        gen_en  = 1'b0;
        case (state_q)
            gauss_pkg::WARMUP: begin
                gen_en = 1'b1;
                warm_d = warm_q + WW'(1);
                if (warm_q == WW'(WARMUP - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                gen_en = ready_q && credit_ok;
            end
            default: begin
                state_d = gauss_pkg::WARMUP;
            end
        endcase
        if (reset) begin
            gen_en = 1'b0;
        end
        disc_d    = disc_q << 1;
        disc_d[0] = gen_en && (state_q == gauss_pkg::WARMUP);
        keep_d    = keep_q << 1;
        keep_d[0] = gen_en && (state_q == RUN);
        ready_d   = ready_q || ((state_q == RUN) && (disc_d == '0));
    end

    // Sequencer state, valid pipe and ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= gauss_pkg::WARMUP;
            warm_q  <= '0;
            disc_q  <= '0;
            keep_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            disc_q  <= disc_d;
            keep_q  <= keep_d;
            ready_q <= ready_d;
        end
    end

    // Sample storage; contents need no reset since count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= gen_data;
        end
    end

    // FIFO pointers/count, round-robin pointer and registered grant outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q        <= rd_q + AW'(1);
                ptr_q       <= next_ptr;
                gnt_q       <= sel;
                out_valid_q <= 1'b1;
                out_data_q  <= mem_q[rd_q];
            end else begin
                gnt_q       <= '0;
                out_valid_q <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == CW'(DEPTH))));

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ready     = ready_q;

`ifdef GAUSS_STATS_EN
    localparam int STARVE_LIM = 4 * N_REQ;
    localparam int SW         = clog2(STARVE_LIM + 1);

    logic [31:0]      grant_count_q;
    logic [SW-1:0]    wait_q [N_REQ];
    logic [N_REQ-1:0] starve_q;

    // Total grants and per-lane consecutive-wait tracking with sticky starve flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_count_q <= '0;
            starve_q      <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                grant_count_q <= grant_count_q + 32'd1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && !(pop && sel[i])) begin
                    if (wait_q[i] == SW'(STARVE_LIM)) begin
                        starve_q[i] <= 1'b1;
                    end else begin
                        wait_q[i] <= wait_q[i] + SW'(1);
                    end
                end else begin
                    wait_q[i] <= '0;
                end
            end
        end
    end

    assign grant_count = grant_count_q;
    assign starve      = starve_q;
`endif

endmodule
